// File: rtl/mdu_unit.sv
// Multiply/divide unit for the E stage: mult/multu/div/divu plus HI/LO moves.
// Latency: MULT_CYCLES or DIV_CYCLES edges after accept; HI/LO update as busy falls.
// Backpressure: none; busy is exported and the hazard unit must stall MDU ops.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt_q,     cnt_d;
  logic [31:0]   hi_q,      hi_d;
  logic [31:0]   lo_q,      lo_d;
  logic [31:0]   temp_hi_q, temp_hi_d;
  logic [31:0]   temp_lo_q, temp_lo_d;
  // Cleared for a divide by zero so the completion edge leaves HI/LO alone.
  logic          wr_q,      wr_d;

  logic          is_signed;
  logic [63:0]   prod;
  logic          a_neg;
  logic          b_neg;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic [31:0]   div_b;
  logic [31:0]   q_mag;
  logic [31:0]   r_mag;
  logic [31:0]   quot;
  logic [31:0]   rem;

  assign busy = (cnt_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Arithmetic datapath: 64-bit product and sign-magnitude division of the live operands.
  always_comb begin
    is_signed = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
    if (is_signed) begin
      prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    end else begin
      prod = {32'd0, A} * {32'd0, B};
    end
    a_neg = is_signed && A[31];
    b_neg = is_signed && B[31];
    a_mag = a_neg ? (32'd0 - A) : A;
    b_mag = b_neg ? (32'd0 - B) : B;
    // Substitute a divisor of 1 for zero; the result is discarded anyway.
    div_b = (B == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / div_b;
    r_mag = a_mag % div_b;
    // 0x80000000 / -1 falls out naturally: both negative, magnitude quotient 0x80000000.
    quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem   = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // Next-state: finish an in-flight op, or accept a start/move when idle and not flushed.
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    wr_d      = wr_q;

    if (busy) begin
      cnt_d = cnt_q - CW'(1);
      if ((cnt_q == CW'(1)) && wr_q) begin
        hi_d = temp_hi_q;
        lo_d = temp_lo_q;
      end
    end else if (!Req) begin
      case (mdu_op)
        OP_MULT, OP_MULTU: begin
          temp_hi_d = prod[63:32];
          temp_lo_d = prod[31:0];
          wr_d      = 1'b1;
          cnt_d     = CW'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          temp_hi_d = rem;
          temp_lo_d = quot;
          wr_d      = (B != 32'd0);
          cnt_d     = CW'(DIV_CYCLES);
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset taking priority over any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      temp_hi_q <= 32'd0;
      temp_lo_q <= 32'd0;
      wr_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      wr_q      <= wr_d;
    end
  end

  // Read mux for mfhi/mflo; always shows the committed registers.
  always_comb begin
    mdu_out = 32'd0;
    case (mdu_op)
      OP_MFHI: mdu_out = hi_q;
      OP_MFLO: mdu_out = lo_q;
      default: mdu_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit with hand-computed expected HI/LO values.
// Inputs change 1 time unit after a rising edge; outputs sampled at the same point.
// Busy durations are measured by counting edges until busy falls (bounded).
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MFHI  = 4'd5;
  localparam logic [3:0] MFLO  = 4'd6;
  localparam logic [3:0] MTHI  = 4'd7;
  localparam logic [3:0] MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic [3:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_out;

  int checks = 0;
  int errors = 0;
  int n;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .Req     (Req),
    .mdu_op  (mdu_op),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .mdu_out (mdu_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for exactly one edge, then return the bus to NONE.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    mdu_op = op;
    A      = a;
    B      = b;
    tick();
    mdu_op = NONE;
  endtask

  // Count edges until busy drops; capped so a stuck busy cannot hang the run.
  task automatic run_wait(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; Req = 1'b0; mdu_op = NONE; A = '0; B = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_out", mdu_out, 32'd0);

    // MULT -2 * 3
    issue(MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy_on", {31'd0, busy}, 32'd1);
    check("mult_hold_lo", lo, 32'd0);
    run_wait(n);
    check("mult_cycles", n, MC);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    mdu_op = MFHI; #1;
    check("mfhi_out", mdu_out, 32'hFFFF_FFFF);
    mdu_op = MFLO; #1;
    check("mflo_out", mdu_out, 32'hFFFF_FFFA);
    mdu_op = NONE;

    // MULTU same operands
    issue(MULTU, 32'hFFFF_FFFE, 32'd3);
    run_wait(n);
    check("multu_cycles", n, MC);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    // DIV -7 / 2
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    run_wait(n);
    check("div_cycles", n, DC);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // DIVU 7 / 2
    issue(DIVU, 32'd7, 32'd2);
    run_wait(n);
    check("divu_cycles", n, DC);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    // Divide by zero keeps previous HI/LO
    issue(MTHI, 32'h1234, 32'd0);
    issue(MTLO, 32'h5678, 32'd0);
    check("mthi", hi, 32'h1234);
    check("mtlo", lo, 32'h5678);
    issue(DIV, 32'd99, 32'd0);
    run_wait(n);
    check("div0_cycles", n, DC);
    check("div0_hi", hi, 32'h1234);
    check("div0_lo", lo, 32'h5678);

    // Overflow case
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_wait(n);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);

    // Req blocks start and moves
    Req = 1'b1;
    issue(MULT, 32'd5, 32'd5);
    check("req_mult_busy", {31'd0, busy}, 32'd0);
    tick(); tick(); tick(); tick(); tick();
    check("req_mult_hi", hi, 32'd0);
    check("req_mult_lo", lo, 32'h8000_0000);
    issue(MTHI, 32'hABCD, 32'd0);
    check("req_mthi", hi, 32'd0);
    Req = 1'b0;

    // Req rising mid-flight does not cancel: 100 / 7 = 14 r 2
    issue(DIV, 32'd100, 32'd7);
    tick(); tick(); tick();
    Req = 1'b1;
    run_wait(n);
    check("req_fly_cycles", n, DC - 3);
    check("req_fly_lo", lo, 32'd14);
    check("req_fly_hi", hi, 32'd2);
    Req = 1'b0;

    // Ops while busy are ignored; MFLO shows old lo
    issue(MULT, 32'd2, 32'd3);
    mdu_op = MULT; A = 32'd100; B = 32'd100;
    tick();
    mdu_op = MTLO; A = 32'hDEAD;
    tick();
    mdu_op = MFLO; #1;
    check("busy_mflo", mdu_out, 32'd14);
    check("busy_still", {31'd0, busy}, 32'd1);
    mdu_op = NONE;
    run_wait(n);
    check("busy_rem_cycles", n, MC - 2);
    check("busy_ign_lo", lo, 32'd6);
    check("busy_ign_hi", hi, 32'd0);

    // Reset in third busy cycle aborts
    issue(MULT, 32'd7, 32'd7);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("abort_late_lo", lo, 32'd0);
    check("abort_late_hi", hi, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
